// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter sharing one FIFO enqueue port among NUM_REQ valid/ready requesters.
// Define FIFO_ENQ_ARB_BURST_EN to lock a granted requester for up to MAX_BURST consecutive beats.
module fifo_enq_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  MAX_BURST  = 4,
    localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                rst_aL,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                fifo_enq_valid,
    output logic [DATA_WIDTH-1:0]               fifo_enq_data,
    input  logic                                fifo_enq_ready,
    output logic [IDX_WIDTH-1:0]                grant_id
);

    if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_bad_param
        $error("fifo_enq_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
    end

    // Wraps at NUM_REQ-1, so non-power-of-two requester counts never reach an unused index.
    function automatic logic [IDX_WIDTH-1:0] idx_inc(input logic [IDX_WIDTH-1:0] i);
        if (i == IDX_WIDTH'(NUM_REQ - 1)) return '0;
        return i + 1'b1;
    endfunction

    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0] search_base;
    logic [IDX_WIDTH-1:0] rr_grant;
    logic [IDX_WIDTH-1:0] grant;
    logic                 any_valid;
    logic                 xfer;

    assign any_valid = |req_valid;
    assign xfer      = any_valid & fifo_enq_ready;

    // First valid requester at or after search_base, circularly; 0 when none is valid.
    always_comb begin
        int                   sum;
        logic [IDX_WIDTH-1:0] cand;
        logic                 found;
        rr_grant = '0;
        found    = 1'b0;
        sum      = 0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(search_base) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            cand = IDX_WIDTH'(sum);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                rr_grant = cand;
            end
        end
    end

`ifdef FIFO_ENQ_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] lock_id_q, lock_id_d;
    logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 locked;

    assign locked      = (state_q == LOCK) && req_valid[lock_id_q];
    assign cnt_inc     = burst_cnt_q + 1'b1;
    // A lock whose owner dropped valid releases this cycle and arbitrates from the next index.
    assign search_base = (state_q == LOCK) ? idx_inc(lock_id_q) : rr_ptr_q;
    assign grant       = locked ? lock_id_q : rr_grant;

    always_comb begin
        state_d     = state_q;
        lock_id_d   = lock_id_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (locked) begin
            if (xfer) begin
                if (cnt_inc == CNT_W'(MAX_BURST)) begin
                    state_d     = IDLE;
                    rr_ptr_d    = idx_inc(lock_id_q);
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = cnt_inc;
                end
            end
        end else begin
            if (state_q == LOCK) begin
                state_d     = IDLE;
                rr_ptr_d    = idx_inc(lock_id_q);
                burst_cnt_d = '0;
            end
            if (xfer) begin
                if (MAX_BURST > 1) begin
                    state_d     = LOCK;
                    lock_id_d   = grant;
                    burst_cnt_d = CNT_W'(1);
                end else begin
                    rr_ptr_d = idx_inc(grant);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q     <= IDLE;
            lock_id_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lock_id_q   <= lock_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign search_base = rr_ptr_q;
    assign grant       = rr_grant;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) rr_ptr_d = idx_inc(grant);
    end
`endif

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) rr_ptr_q <= '0;
        else         rr_ptr_q <= rr_ptr_d;
    end

    assign fifo_enq_valid = any_valid;
    assign fifo_enq_data  = req_data[grant];
    assign grant_id       = grant;
    assign req_ready      = xfer ? (NUM_REQ'(1) << grant) : '0;

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Scoreboard bench for fifo_enq_arbiter: per-cycle expected grants are queued by the driver
// and checked by a negedge monitor; expectations follow the build selected by FIFO_ENQ_ARB_BURST_EN.
module tb_fifo_enq_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int MAX_BURST  = 4;
    localparam int IDX_WIDTH  = 2;

    logic                                clk = 1'b0;
    logic                                rst_aL = 1'b0;
    logic [NUM_REQ-1:0]                  req_valid = '0;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data;
    logic [NUM_REQ-1:0]                  req_ready;
    logic                                fifo_enq_valid;
    logic [DATA_WIDTH-1:0]               fifo_enq_data;
    logic                                fifo_enq_ready = 1'b1;
    logic [IDX_WIDTH-1:0]                grant_id;

    fifo_enq_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .rst_aL        (rst_aL),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_enq_valid(fifo_enq_valid),
        .fifo_enq_data (fifo_enq_data),
        .fifo_enq_ready(fifo_enq_ready),
        .grant_id      (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   n;
        logic                 vld;
        logic [NUM_REQ-1:0]   rdyv;
        logic [IDX_WIDTH-1:0] gid;
        logic [DATA_WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   n_step   = 0;

    function automatic logic [DATA_WIDTH-1:0] tag(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0101_0011;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus plus its expected outputs.
    task automatic step(input logic rst_n, input logic [3:0] v, input logic rdy, input int gid);
        exp_t e;
        @(posedge clk);
        #1;
        rst_aL         = rst_n;
        req_valid      = v;
        fifo_enq_ready = rdy;
        e.n    = n_step;
        e.vld  = |v;
        e.gid  = gid[IDX_WIDTH-1:0];
        e.rdyv = (rdy && v != 4'b0000) ? (4'b0001 << gid) : 4'b0000;
        e.data = tag(gid);
        n_step++;
        sb.push_back(e);
    endtask

    task automatic beats(input logic [3:0] v, input int count, input int gid);
        for (int i = 0; i < count; i++) step(1'b1, v, 1'b1, gid);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk($sformatf("c%0d_enq_valid", mon_e.n), 64'(fifo_enq_valid), 64'(mon_e.vld));
            chk($sformatf("c%0d_grant_id", mon_e.n), 64'(grant_id), 64'(mon_e.gid));
            chk($sformatf("c%0d_req_ready", mon_e.n), 64'(req_ready), 64'(mon_e.rdyv));
            chk($sformatf("c%0d_enq_data", mon_e.n), 64'(fifo_enq_data), 64'(mon_e.data));
        end
    end

    // Requesters must hold valid and data until their handshake.
    logic [NUM_REQ-1:0]                 pend_q;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_q;
    always @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pend_q[i])
                    assert (req_valid[i] && req_data[i] == data_q[i])
                    else $error("requester %0d dropped valid or changed data before ready", i);
            end
            pend_q <= req_valid & ~req_ready;
            data_q <= req_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) req_data[i] = tag(i);

        // Reset with no requests, then a single requester wherever the pointer sits
        step(1'b0, 4'b0000, 1'b1, 0);
        step(1'b0, 4'b0000, 1'b1, 0);
        step(1'b1, 4'b0100, 1'b1, 2);
        step(1'b1, 4'b0100, 1'b1, 2);
        step(1'b1, 4'b0000, 1'b1, 0);
        step(1'b1, 4'b0001, 1'b1, 0);

`ifdef FIFO_ENQ_ARB_BURST_EN
        // Two requesters held: four beats each, then back to 0
        step(1'b0, 4'b0000, 1'b1, 0);
        beats(4'b0011, 4, 0);
        beats(4'b0011, 4, 1);
        beats(4'b0011, 1, 0);

        // Sparse valids: bursts on 1 and 3
        step(1'b0, 4'b0000, 1'b1, 0);
        beats(4'b1010, 4, 1);
        beats(4'b1010, 4, 3);
        beats(4'b1010, 1, 1);

        // FIFO full before and during a lock on requester 2
        step(1'b0, 4'b0000, 1'b1, 0);
        beats(4'b1111, 4, 0);
        beats(4'b1111, 4, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 1'b0, 2);
        beats(4'b1111, 1, 2);
        for (int i = 0; i < 2; i++) step(1'b1, 4'b1111, 1'b0, 2);
        beats(4'b1111, 3, 2);
        beats(4'b1111, 1, 3);

        // Lock owner drops after two beats: requester 1 takes over the same cycle
        step(1'b0, 4'b0000, 1'b1, 0);
        beats(4'b0011, 2, 0);
        beats(4'b0010, 4, 1);
        beats(4'b0011, 1, 0);

        // Reset in the middle of a lock on requester 1
        step(1'b0, 4'b0000, 1'b1, 0);
        beats(4'b0011, 4, 0);
        beats(4'b0011, 2, 1);
        step(1'b0, 4'b0011, 1'b1, 0);
        beats(4'b1111, 1, 0);
`else
        // All valid: strict rotation
        step(1'b0, 4'b0000, 1'b1, 0);
        for (int i = 0; i < 6; i++) beats(4'b1111, 1, i % 4);

        // Sparse valids: wrap from 3 skips invalid 0
        step(1'b0, 4'b0000, 1'b1, 0);
        for (int i = 0; i < 4; i++) beats(4'b1010, 1, (i % 2 == 0) ? 1 : 3);

        // FIFO full for three cycles with the grant on 2
        step(1'b0, 4'b0000, 1'b1, 0);
        beats(4'b1111, 1, 0);
        beats(4'b1111, 1, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 1'b0, 2);
        beats(4'b1111, 1, 2);
        beats(4'b1111, 1, 3);
        beats(4'b1111, 1, 0);

        // Reset mid-stream with the pointer at 2
        step(1'b0, 4'b0000, 1'b1, 0);
        beats(4'b1111, 1, 0);
        beats(4'b1111, 1, 1);
        step(1'b0, 4'b1111, 1'b1, 0);
        beats(4'b1111, 1, 0);
        beats(4'b1111, 1, 1);
`endif

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_enq_arbiter.md
# fifo_enq_arbiter

Round-robin arbiter that shares the enqueue port of a single downstream FIFO among `NUM_REQ` requesters using valid/ready handshakes. It sits directly in front of the FIFO's enq port and forwards at most one beat per cycle. It keeps rotating-priority state so that no continuously-valid requester is starved. Optionally, a granted requester can be locked for a burst of consecutive beats.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; must be ≥ 2.
- `DATA_WIDTH`, 32: payload width.
- `MAX_BURST`, 4: maximum consecutive beats per lock. Used only with `FIFO_ENQ_ARB_BURST_EN`. Must be ≥ 1.
- `IDX_WIDTH` (localparam), `$clog2(NUM_REQ)`.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_aL`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, `NUM_REQ`: per-requester valid.
- `req_data`, in, `NUM_REQ` x `DATA_WIDTH`: per-requester payload.
- `req_ready`, out, `NUM_REQ`: one-hot or zero; asserted for the granted requester when `fifo_enq_ready` is high.
- `fifo_enq_valid`, out, 1: drives the FIFO's enq_valid.
- `fifo_enq_data`, out, `DATA_WIDTH`: equals `req_data[grant_id]`.
- `fifo_enq_ready`, in, 1: the FIFO's enq_ready, i.e. not full.
- `grant_id`, out, `IDX_WIDTH`: index of the current grant. 0 when no requester is valid.

## Operation
- State: `rr_ptr` (`IDX_WIDTH`), the highest-priority index.
- Grant is combinational from `req_valid` and state only; it never depends on `fifo_enq_ready`, so there is no combinational loop through the FIFO.
- `grant_id` is the first index `i` with `req_valid[i]`, searching circularly from `rr_ptr` upward through `NUM_REQ-1`, then from 0.
- `fifo_enq_valid` is `|req_valid`.
- `req_ready[i]` is `fifo_enq_ready && fifo_enq_valid && (i == grant_id)`.
- A transfer (`xfer`) occurs when `fifo_enq_valid && fifo_enq_ready`. Exactly one requester and one FIFO slot are consumed.
- On `xfer`, `rr_ptr` becomes `grant_id + 1` mod `NUM_REQ`. The wrap from `NUM_REQ-1` goes to 0, including when `NUM_REQ` is not a power of two.
- With no `xfer` (FIFO full or no requester valid), all state holds. A stalled grant may change if valids change.
- Requester rule: once `req_valid` is asserted, the requester holds `req_valid` and `req_data` stable until its `req_ready`. The arbiter does not check this; the bench asserts it.
- Fairness: a continuously-valid requester is granted within `NUM_REQ` transfers, or `NUM_REQ*MAX_BURST` with burst enabled.

## Timing
- Reset (asynchronous, on `rst_aL` low): `rr_ptr`=0 (burst state IDLE, `burst_cnt`=0).
  - During reset, outputs follow the combinational rules with reset state: for example, all `req_valid`=0 gives `fifo_enq_valid`=0, `req_ready`=0 and `grant_id`=0.
- Latency: zero cycles from request to `fifo_enq_valid`. The data is captured by the FIFO at the same edge as `xfer`.
- Throughput: one beat per cycle while the FIFO is not full.
- Boundary conditions:
  - FIFO full: `req_ready` is all 0 and the pointer holds.
  - Single valid requester: granted every cycle regardless of `rr_ptr`.
  - Reset mid-stream: the in-flight beat is not transferred and state returns to reset values immediately.

## Configuration
- `FIFO_ENQ_ARB_BURST_EN` defined: adds burst locking.
  - Adds FSM {IDLE, LOCK}, `lock_id` and `burst_cnt` (width `$clog2(MAX_BURST)+1`).
  - IDLE with `xfer`:
    - If `MAX_BURST` > 1: go to LOCK, with `lock_id`=`grant_id` and `burst_cnt`=1. `rr_ptr` is not updated.
    - If `MAX_BURST` = 1: behave as the non-burst build.
  - LOCK with `req_valid[lock_id]`: `grant_id` is forced to `lock_id`. Each `xfer` increments `burst_cnt`.
  - LOCK ending on the count: the `xfer` that brings `burst_cnt` to `MAX_BURST` goes to IDLE, with `rr_ptr`=`lock_id+1` mod `NUM_REQ` and `burst_cnt`=0.
  - LOCK with `req_valid[lock_id]`=0: the lock releases in that same cycle.
    - Arbitration uses the normal round-robin from `rr_ptr`=`lock_id+1`.
    - Next state is IDLE, or a new LOCK if a transfer occurs, treated as an IDLE `xfer`.
    - No bubble cycle.
  - LOCK with FIFO full: everything holds.
- `FIFO_ENQ_ARB_BURST_EN` undefined: pure per-beat round-robin as in Operation. No FSM or counter logic is present.

## Test plan
- Reset, all `req_valid`=0 → `fifo_enq_valid`=0, `req_ready`=0, `grant_id`=0. Then `req_valid`=4'b0100 → `grant_id`=2 and `req_ready`=4'b0100 in the same cycle.
- Non-burst build, `req_valid`=4'b1111 held, `fifo_enq_ready`=1 → grant order 0,1,2,3,0,1; `fifo_enq_data` matches each requester's tag.
- Non-burst build, `req_valid`=4'b1010 → grants alternate 1,3,1,3. Wrap from 3 lands on 1 (skipping invalid 0).
- `fifo_enq_ready`=0 for 3 cycles mid-stream, with grant at 2 → `req_ready`=0 and `grant_id` stays 2; the first ready cycle transfers requester 2, then grants 3.
- Burst build, `MAX_BURST`=4, `req_valid`=4'b0011 held → 4 beats from 0, then 4 beats from 1, then 0 again.
  - Variant: drop `req_valid[0]` after 2 beats → requester 1 is granted the same cycle and locks.
- Reset asserted while `burst_cnt`=2 in LOCK → state IDLE, `rr_ptr`=0; after release with all valid, the first grant is 0.
